// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the 8-bit combinational ALU: accumulator, 4x8 register file, 3-cycle issue.
// Optional zero/negative flags are built when ALU_SEQ_FLAGS_EN is defined; otherwise flag_z/flag_n read 0.
//
// state | meaning
// IDLE  | ready for an instruction; latch op, operands and rsel on accept
// EXEC  | ALU sees stable X/Y/op; writeback at the end of the cycle
// DONE  | done pulse, instruction retired
module alu_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic             instr_imm_en,
   input  logic [1:0]       instr_rsel,
   input  logic [WIDTH-1:0] instr_imm,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic             alu_c2,
   output logic             alu_c1,
   output logic             alu_c0,
   input  logic [WIDTH-1:0] alu_f,
   output logic [WIDTH-1:0] acc,
   output logic             done,
   output logic             flag_z,
   output logic             flag_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_STA = 3'b011;

   state_t           state;
   logic [2:0]       op_q;
   logic [1:0]       rsel_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] regfile [NREGS];
   logic             done_q;
   logic [WIDTH-1:0] wb_value;

   // LDA bypasses the ALU, which drives 0 for that op code.
   assign wb_value = (op_q == OP_LDA) ? y_q : alu_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= '0;
         rsel_q <= '0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q   <= instr_op;
                  y_q    <= instr_imm_en ? instr_imm : regfile[instr_rsel];
                  x_q    <= acc_q;
                  rsel_q <= instr_rsel;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (op_q == OP_STA) regfile[rsel_q] <= acc_q;
               else                acc_q           <= wb_value;
               done_q <= 1'b1;
               state  <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic flag_z_q;
   logic flag_n_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else if (state == EXEC && op_q != OP_STA) begin
         flag_z_q <= (wb_value == '0);
         flag_n_q <= wb_value[WIDTH-1];
      end
   end

   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
`else
   assign flag_z = 1'b0;
   assign flag_n = 1'b0;
`endif

   // Ready drops combinationally with rst so no instruction is offered during reset.
   assign instr_ready = (state == IDLE) && !rst;
   assign done        = done_q && !rst;
   assign acc         = acc_q;
   assign alu_x       = x_q;
   assign alu_y       = y_q;
   assign {alu_c2, alu_c1, alu_c0} = op_q;

endmodule
